des_round_sequencer: RTL and testbench
======================================

# des_round_sequencer

Iterative controller that runs a 64-bit block through the 16 DES rounds on a single shared `round` datapath instance instead of 16 unrolled copies. The block accepts an initial-permuted block over a valid/ready handshake. Each cycle it drives the shared round's input and selects that cycle's 48-bit subkey from the `round_key_generator` bus, in forward order for encryption and reverse order for decryption. After the last round it presents the result for `final_permutation` over a second valid/ready handshake.

## Interface
- `ROUNDS`, 16: rounds per block; legal range 1..16; values below 16 are for reduced-round bring-up only.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_block` and `in_decrypt` are valid.
- `in_ready` output 1: the block can be accepted this cycle.
- `in_block` input 64: block already passed through `initial_permutation`.
- `in_decrypt` input 1: 1 = decrypt (reverse key order), 0 = encrypt.
- `round_in` output 64: data input to the shared `round` instance; always equals the internal state register.
- `round_out` input 64: combinational output of the shared `round` instance.
- `key_sel` output 4: subkey index k. External mux selects the 768-bit key bus slice [767-48k -: 48]; k = 0 selects bits 767:720.
- `out_valid` output 1: `out_block` holds the completed block.
- `out_ready` input 1: downstream (`final_permutation` consumer) accepts the block.
- `out_block` output 64: round-ROUNDS output, before final permutation.
- `busy` output 1: the FSM is in RUN.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid` is high: state_reg <= `in_block`, mode <= `in_decrypt`, rnd <= 0, go to RUN.
  - RUN: every cycle, state_reg <= `round_out` and rnd <= rnd+1. When rnd == ROUNDS-1, go to DONE instead of incrementing.
  - DONE: `out_valid`=1 and `out_block`=state_reg, both held stable until `out_ready` is high.
    - `out_ready`=1 and `in_valid`=0: go to IDLE.
    - `out_ready`=1 and `in_valid`=1: the new block is accepted directly (load as in IDLE, go to RUN).
- `in_ready` = IDLE | (DONE & `out_ready`), combinational.
- `key_sel`:
  - in RUN, encrypt: rnd.
  - in RUN, decrypt: 15-rnd. With ROUNDS < 16, decrypt still starts at index 15.
  - outside RUN: 0.
- rnd is a 4-bit counter. It never wraps, because RUN exits at ROUNDS-1 ≤ 15.
- The controller performs no L/R swap or permutation; the `round` datapath and the external permutations own those.
- `in_block`/`in_decrypt` are ignored outside the accept cycle. Mode is latched per block; changing `in_decrypt` mid-RUN has no effect.
- `in_valid` while RUN or DONE-without-`out_ready`: not accepted; the source must hold the request.

## Timing
- Reset values: state IDLE, state_reg 0, rnd 0, mode 0. Therefore `in_ready`=1, `out_valid`=0, `busy`=0, `key_sel`=0, `round_in`=0, `out_block`=0 (`out_block` is 0 whenever not in DONE).
- Acceptance edge = E0. Rounds are computed on edges E1..E_ROUNDS. `out_valid` rises in the cycle after E_ROUNDS, i.e. latency ROUNDS+1 cycles from accept to `out_valid` (17 for DES).
- Back-to-back with `out_ready` tied high: one block every ROUNDS+1 cycles. The output handshake and the next input accept share one edge.
- `rst` mid-RUN or in DONE: the block is discarded with no `out_valid` pulse, and all reset values apply from the next cycle.
- `rst` has priority over every handshake in the same cycle.

## Test plan
- Encrypt, full datapath: key bus from `round_key_generator` with 56-bit key F0CCAAF556678F; IP(0123456789ABCDEF) fed in; final_permutation(`out_block`) == 85E813540F0AB405; `out_valid` 17 cycles after accept; `key_sel` sequence 0,1,…,15.
- Decrypt same key: IP(85E813540F0AB405) in, `in_decrypt`=1 → final output 0123456789ABCDEF; `key_sel` sequence 15,14,…,0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_block` stable, `in_ready`=0, extra `in_valid` not accepted; release → exactly one output handshake.
- Back-to-back: `in_valid` and `out_ready` held high, 4 alternating enc/dec blocks → accepts every 17 cycles, no bubble, each result correct.
- Reset at rnd=7 mid-RUN → the next cycle shows IDLE reset values; no `out_valid`; a subsequent block yields the correct result.
- `in_decrypt` toggled during RUN and `ROUNDS`=4 build → mode unchanged mid-block; 4-round build gives `key_sel` 15,14,13,12 on decrypt, `out_valid` 5 cycles after accept.

Source files
------------

// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: time-multiplexes one shared round datapath
// over ROUNDS cycles per block, sequencing subkeys forward or in reverse.
module des_round_sequencer #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic        in_decrypt,
  output logic [63:0] round_in,
  input  logic [63:0] round_out,
  output logic [3:0]  key_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy
);

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
  localparam logic [3:0] LAST_KEY = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] data_q,  data_d;
  logic [3:0]  rnd_q,   rnd_d;
  logic        mode_q,  mode_d;
  logic        load;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state; a block completing in DONE hands the same edge to a new accept
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rnd_d    = rnd_q;
    mode_d   = mode_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        data_d = round_out;
        if (rnd_q == LAST_RND) begin
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    load = in_ready && in_valid;
    if (load) begin
      state_d = RUN;
      data_d  = in_block;
      mode_d  = in_decrypt;
      rnd_d   = '0;
    end
  end

  // Output decode; decrypt always starts from the last subkey, even in short builds
  always_comb begin
    round_in  = data_q;
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
    out_block = (state_q == DONE) ? data_q : '0;
    key_sel   = '0;
    if (state_q == RUN) begin
      key_sel = mode_q ? (LAST_KEY - rnd_q) : rnd_q;
    end
  end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: DES round model on the shared datapath,
// per-cycle reference model, directed sequences and a 4-round vector table.
module tb_des_round_sequencer;

  localparam int NR = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-round instance
  logic        rst, in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0] in_block, round_in, round_out, out_block;
  logic [3:0]  key_sel;
  // 4-round instance
  logic        rst_4, in_valid_4, in_ready_4, in_decrypt_4, out_valid_4, out_ready_4, busy_4;
  logic [63:0] in_block_4, round_in_4, round_out_4, out_block_4;
  logic [3:0]  key_sel_4;

  des_round_sequencer #(.ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_decrypt(in_decrypt), .round_in(round_in),
    .round_out(round_out), .key_sel(key_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  des_round_sequencer #(.ROUNDS(4)) dut4 (
    .clk(clk), .rst(rst_4), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .in_block(in_block_4), .in_decrypt(in_decrypt_4), .round_in(round_in_4),
    .round_out(round_out_4), .key_sel(key_sel_4), .out_valid(out_valid_4),
    .out_ready(out_ready_4), .out_block(out_block_4), .busy(busy_4)
  );

  // ---------------- DES tables ----------------
  int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int p_t [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                     16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                     44,49,39,56,34,53, 46,42,50,36,29,32};
  int shift_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sbox_t [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic [47:0]  sk [16];
  logic [767:0] kbus;
  logic [47:0]  subkey, subkey_4;

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - ip_t[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(64 - ip_t[i])] = x[6'(63 - i)];
    return y;
  endfunction

  function automatic logic [31:0] f_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    logic [5:0]  six;
    int          row, col;
    for (int j = 0; j < 8; j++)
      for (int m = 0; m < 6; m++)
        e[6'(47 - 6*j - m)] = r[5'(31 - ((4*j + m + 31) % 32))];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      six = e[6'(47 - 6*j) -: 6];
      row = int'({six[5], six[0]});
      col = int'(six[4:1]);
      s[5'(31 - 4*j) -: 4] = 4'(sbox_t[j*64 + row*16 + col]);
    end
    for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - p_t[i])];
    return p;
  endfunction

  function automatic logic [63:0] round_f(input logic [63:0] x, input logic [47:0] k);
    return {x[31:0], x[63:32] ^ f_f(x[31:0], k)};
  endfunction

  function automatic logic [63:0] swap_f(input logic [63:0] x);
    return {x[31:0], x[63:32]};
  endfunction

  // Expected state after n rounds of a block in the given mode
  function automatic logic [63:0] ref_run(input logic [63:0] b, input logic dec, input int n);
    logic [63:0] x;
    x = b;
    for (int i = 0; i < n; i++) x = round_f(x, sk[dec ? 15 - i : i]);
    return x;
  endfunction

  task automatic build_keys(input logic [55:0] key56);
    logic [27:0] c, d;
    logic [55:0] cd;
    c = key56[55:28];
    d = key56[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < shift_t[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int b = 0; b < 48; b++) sk[i][6'(47 - b)] = cd[6'(56 - pc2_t[b])];
      kbus[10'(767 - 48*i) -: 48] = sk[i];
    end
  endtask

  // Shared round datapaths fed through the key-bus slice mux
  always_comb begin
    subkey      = kbus[10'(767 - 48*int'(key_sel)) -: 48];
    round_out   = round_f(round_in, subkey);
    subkey_4    = kbus[10'(767 - 48*int'(key_sel_4)) -: 48];
    round_out_4 = round_f(round_in_4, subkey_4);
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: age = edges since accept; RUN for 1..NR, DONE at NR+1
  bit          m_known = 0, m_have = 0, m_dec = 0;
  int          m_age = 0;
  logic [63:0] m_blk = '0, m_last = '0;
  logic        o_acc, o_hs, o_valid, o_busy, o_ir;
  logic [3:0]  o_key;
  logic [63:0] o_blk, o_ri;
  logic [3:0]  key_log [$];

  task automatic cycle(input logic r, input logic iv, input logic [63:0] blk,
                       input logic dec, input logic ordy);
    logic        e_run, e_done, e_ir;
    logic [3:0]  e_key;
    logic [63:0] e_ri, e_ob;
    @(negedge clk);
    rst = r; in_valid = iv; in_block = blk; in_decrypt = dec; out_ready = ordy;
    #1;
    e_run  = m_have && (m_age <= NR);
    e_done = m_have && (m_age == NR + 1);
    e_ir   = !m_have || (e_done && ordy);
    e_key  = e_run ? 4'(m_dec ? 15 - (m_age - 1) : m_age - 1) : 4'd0;
    e_ri   = !m_have ? m_last : ref_run(m_blk, m_dec, e_run ? m_age - 1 : NR);
    e_ob   = e_done ? e_ri : 64'd0;
    if (m_known) begin
      chk("in_ready",  64'(in_ready),  64'(e_ir));
      chk("out_valid", 64'(out_valid), 64'(e_done));
      chk("busy",      64'(busy),      64'(e_run));
      chk("key_sel",   64'(key_sel),   64'(e_key));
      chk("round_in",  round_in,       e_ri);
      chk("out_block", out_block,      e_ob);
    end
    o_acc = in_valid && in_ready && !rst;
    o_hs  = out_valid && out_ready && !rst;
    o_valid = out_valid; o_busy = busy; o_ir = in_ready;
    o_key = key_sel; o_blk = out_block; o_ri = round_in;
    @(posedge clk);
    if (r) begin
      m_known = 1; m_have = 0; m_last = '0; m_dec = 0;
    end else begin
      if (e_done && ordy) begin
        m_have = 0;
        m_last = e_ri;
      end
      if (iv && e_ir) begin
        m_have = 1; m_age = 1; m_blk = blk; m_dec = dec;
      end else if (m_have && m_age <= NR) begin
        m_age++;
      end
    end
  endtask

  task automatic wait_done(output int lat, output logic [63:0] res);
    lat = 0;
    res = '0;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b0, 1'b0, 64'd0, logic'(i[0]), 1'b0);
      if (o_busy) key_log.push_back(o_key);
      if (o_valid) begin
        lat = i;
        res = o_blk;
        break;
      end
    end
  endtask

  typedef struct {
    logic        r, iv;
    logic [63:0] blk;
    logic        dec, ordy;
    logic        e_ir, e_ov, e_busy;
    logic [3:0]  e_key;
    logic        cb;
    logic [63:0] e_blk;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [63:0] res, pt_ip, ct_ip, b4a, b4b, b4c;
    logic [63:0] bb_blk [4];
    logic        bb_dec [4];
    logic [63:0] bb_res [4];
    int          acc_cyc [4];
    int          lat, nacc, nres, cnt;

    rst = 1; in_valid = 0; in_block = '0; in_decrypt = 0; out_ready = 0;
    rst_4 = 1; in_valid_4 = 0; in_block_4 = '0; in_decrypt_4 = 0; out_ready_4 = 0;
    kbus = '0;
    build_keys(56'hF0CCAAF556678F);
    pt_ip = ip_f(64'h0123456789ABCDEF);
    ct_ip = ip_f(64'h85E813540F0AB405);

    // Reset values
    cycle(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'hDEAD, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("reset_in_ready", 64'(o_ir), 64'd1);
    chk("reset_round_in", o_ri, 64'd0);

    // Encrypt known answer
    key_log.delete();
    cycle(1'b0, 1'b1, pt_ip, 1'b0, 1'b0);
    chk("enc_accept", 64'(o_acc), 64'd1);
    wait_done(lat, res);
    chk("enc_latency", 64'(lat), 64'd17);
    chk("enc_result", fp_f(swap_f(res)), 64'h85E813540F0AB405);
    chk("enc_key_count", 64'(key_log.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("enc_key_seq[%0d]", i), 64'(i < key_log.size() ? key_log[i] : 4'hX), 64'(i));
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("enc_handshake", 64'(o_hs), 64'd1);

    // Decrypt known answer
    key_log.delete();
    cycle(1'b0, 1'b1, ct_ip, 1'b1, 1'b0);
    wait_done(lat, res);
    chk("dec_latency", 64'(lat), 64'd17);
    chk("dec_result", fp_f(swap_f(res)), 64'h0123456789ABCDEF);
    chk("dec_key_count", 64'(key_log.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("dec_key_seq[%0d]", i), 64'(i < key_log.size() ? key_log[i] : 4'hX), 64'(15 - i));
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

    // Backpressure: hold DONE for 5 cycles with a competing request
    cycle(1'b0, 1'b1, 64'h1122334455667788, 1'b0, 1'b0);
    wait_done(lat, res);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 64'hCAFEF00DCAFEF00D, 1'b1, 1'b0);
      chk("bp_block_stable", o_blk, ref_run(64'h1122334455667788, 1'b0, NR));
      chk("bp_in_ready", 64'(o_ir), 64'd0);
      cnt += int'(o_acc);
    end
    chk("bp_no_accept", 64'(cnt), 64'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
      cnt += int'(o_hs);
    end
    chk("bp_one_handshake", 64'(cnt), 64'd1);

    // Back-to-back alternating enc/dec with in_valid and out_ready high
    bb_blk = '{pt_ip, ct_ip, 64'h0F1E2D3C4B5A6978, 64'h8877665544332211};
    bb_dec = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      acc_cyc[i] = -1000 * (i + 1);
      bb_res[i] = '0;
    end
    nacc = 0;
    nres = 0;
    for (int c = 0; c < 120 && nres < 4; c++) begin
      cycle(1'b0, nacc < 4, bb_blk[nacc & 3], bb_dec[nacc & 3], 1'b1);
      if (o_hs) begin
        bb_res[nres & 3] = o_blk;
        nres++;
      end
      if (o_acc) begin
        acc_cyc[nacc & 3] = c;
        nacc++;
      end
    end
    chk("b2b_outputs", 64'(nres), 64'd4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("b2b_spacing[%0d]", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd17);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_result[%0d]", i), bb_res[i], ref_run(bb_blk[i], bb_dec[i], NR));
    chk("b2b_enc_kat", fp_f(swap_f(bb_res[0])), 64'h85E813540F0AB405);
    chk("b2b_dec_kat", fp_f(swap_f(bb_res[1])), 64'h0123456789ABCDEF);

    // Reset at rnd 7 mid-RUN
    cycle(1'b0, 1'b1, 64'hA5A5A5A55A5A5A5A, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("rst_at_rnd7_key", 64'(o_key), 64'd7);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("post_rst_busy", 64'(o_busy), 64'd0);
    chk("post_rst_round_in", o_ri, 64'd0);
    chk("post_rst_in_ready", 64'(o_ir), 64'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
      cnt += int'(o_valid);
    end
    chk("post_rst_no_valid", 64'(cnt), 64'd0);
    cycle(1'b0, 1'b1, pt_ip, 1'b0, 1'b0);
    wait_done(lat, res);
    chk("post_rst_result", fp_f(swap_f(res)), 64'h85E813540F0AB405);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 60, {$urandom, $urandom},
            1'($urandom), $urandom_range(0, 99) < 50);

    // 4-round build: vector table, mode toggled mid-block
    b4a = 64'h0123456789ABCDEF;
    b4b = 64'hFEDCBA9876543210;
    b4c = 64'h1357924680ACEBDF;
    //          r  iv blk         dec ordy ir ov bsy key    cb  e_blk
    tbl[0]  = '{1, 0, 64'd0,       0, 0,   1, 0, 0, 4'd0,  1, 64'd0};
    tbl[1]  = '{0, 0, 64'd0,       0, 0,   1, 0, 0, 4'd0,  1, 64'd0};
    tbl[2]  = '{0, 1, b4a,         1, 0,   1, 0, 0, 4'd0,  1, 64'd0};
    tbl[3]  = '{0, 0, 64'd0,       0, 0,   0, 0, 1, 4'd15, 1, 64'd0};
    tbl[4]  = '{0, 0, 64'd0,       1, 0,   0, 0, 1, 4'd14, 0, 64'd0};
    tbl[5]  = '{0, 0, 64'd0,       0, 0,   0, 0, 1, 4'd13, 0, 64'd0};
    tbl[6]  = '{0, 1, b4c,         1, 1,   0, 0, 1, 4'd12, 0, 64'd0};
    tbl[7]  = '{0, 1, b4c,         0, 0,   0, 1, 0, 4'd0,  1, ref_run(b4a, 1'b1, 4)};
    tbl[8]  = '{0, 0, 64'd0,       0, 1,   1, 1, 0, 4'd0,  1, ref_run(b4a, 1'b1, 4)};
    tbl[9]  = '{0, 0, 64'd0,       0, 0,   1, 0, 0, 4'd0,  1, 64'd0};
    tbl[10] = '{0, 1, b4b,         0, 0,   1, 0, 0, 4'd0,  0, 64'd0};
    tbl[11] = '{0, 0, 64'd0,       1, 0,   0, 0, 1, 4'd0,  0, 64'd0};
    tbl[12] = '{0, 0, 64'd0,       0, 0,   0, 0, 1, 4'd1,  0, 64'd0};
    tbl[13] = '{0, 0, 64'd0,       1, 0,   0, 0, 1, 4'd2,  0, 64'd0};
    tbl[14] = '{0, 0, 64'd0,       0, 0,   0, 0, 1, 4'd3,  1, 64'd0};
    tbl[15] = '{0, 1, b4c,         1, 1,   1, 1, 0, 4'd0,  1, ref_run(b4b, 1'b0, 4)};
    tbl[16] = '{0, 0, 64'd0,       0, 0,   0, 0, 1, 4'd15, 1, 64'd0};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst_4 = tbl[i].r; in_valid_4 = tbl[i].iv; in_block_4 = tbl[i].blk;
      in_decrypt_4 = tbl[i].dec; out_ready_4 = tbl[i].ordy;
      #1;
      chk($sformatf("r4_in_ready[%0d]", i),  64'(in_ready_4),  64'(tbl[i].e_ir));
      chk($sformatf("r4_out_valid[%0d]", i), 64'(out_valid_4), 64'(tbl[i].e_ov));
      chk($sformatf("r4_busy[%0d]", i),      64'(busy_4),      64'(tbl[i].e_busy));
      chk($sformatf("r4_key_sel[%0d]", i),   64'(key_sel_4),   64'(tbl[i].e_key));
      if (tbl[i].cb) chk($sformatf("r4_out_block[%0d]", i), out_block_4, tbl[i].e_blk);
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
